reset_sequencer: RTL

//  Board-level reset/clock-bring-up controller between board pins and the soc.

---
 rtl/reset_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: debounces the reset button, pulses the MMCM reset,
// waits for a stable lock and releases the domain resets in staggered order.
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1,
  parameter int unsigned PLL_RST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT    = 100000,
  parameter int unsigned HOLD_CYCLES     = 256,
  parameter int unsigned STAGGER_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_i,
  input  logic                   pll_locked_i,
  output logic                   pll_rst_o,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   ready_o,
  output logic [1:0]             cause_o,
  output logic                   lock_fail_o
);

  localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int unsigned MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B    = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
  localparam int unsigned MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] CAUSE_POR     = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON  = 2'd1;
  localparam logic [1:0] CAUSE_LOST    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_sat;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lk;
  logic                   btn_pressed;
  logic                   db_state;
  logic [DEB_W-1:0]       db_cnt;
  logic                   db_flip;
  logic                   press;
  logic [CNT_W:0]         rel_elapsed;
  logic [NUM_DOMAINS-1:0] rel_mask;
  logic                   rel_done;
  logic                   restart;
  logic [1:0]             restart_cause;
  logic                   timeout;

  // Two-flop (or deeper) synchronisers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_sync <= '0;
      btn_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign lk          = lock_sync[SYNC_STAGES-1];
  assign btn_pressed = BTN_ACTIVE_HIGH ? btn_sync[SYNC_STAGES-1] : ~btn_sync[SYNC_STAGES-1];

  // Debounce: filtered level flips only after an unbroken run of differing samples
  assign db_flip = (btn_pressed != db_state) && (db_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign press   = db_flip && !db_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_state <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_pressed == db_state) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_state <= ~db_state;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + DEB_W'(1);
    end
  end

  assign cnt_sat = (cnt == CNT_W'(MAX_CNT)) ? cnt : cnt + CNT_W'(1);

  // Domains whose release offset has been reached on the coming edge
  always_comb begin
    rel_mask    = '0;
    rel_elapsed = {1'b0, cnt} + (CNT_W + 1)'(1);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      rel_mask[i] = (32'(rel_elapsed) >= 32'(i) * STAGGER_CYCLES);
    end
    rel_done = (32'(rel_elapsed) == REL_SPAN);
  end

  // Restart requests, already ordered lock loss before button before timers
  always_comb begin
    restart       = 1'b0;
    restart_cause = cause_o;
    timeout       = 1'b0;
    unique case (state)
      S_WAIT_LOCK: begin
        if (!lk && cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          restart       = 1'b1;
          restart_cause = CAUSE_TIMEOUT;
          timeout       = 1'b1;
        end
      end
      S_HOLD: restart = !lk;
      S_RELEASE, S_RUN: begin
        if (!lk) begin
          restart       = 1'b1;
          restart_cause = CAUSE_LOST;
        end else if (press) begin
          restart       = 1'b1;
          restart_cause = CAUSE_BUTTON;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      pll_rst_o   <= 1'b1;
      rst_n_o     <= '0;
      ready_o     <= 1'b0;
      cause_o     <= CAUSE_POR;
      lock_fail_o <= 1'b0;
    end else if (restart) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst_o <= 1'b1;
      rst_n_o   <= '0;
      ready_o   <= 1'b0;
      cause_o   <= restart_cause;
      if (timeout) lock_fail_o <= 1'b1;
    end else begin
      cnt <= cnt_sat;
      unique case (state)
        S_PLL_RST: begin
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            pll_rst_o <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt     <= '0;
            rst_n_o <= NUM_DOMAINS'(1);
            if (NUM_DOMAINS == 1) begin
              state   <= S_RUN;
              ready_o <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          rst_n_o <= rel_mask;
          if (rel_done) begin
            state   <= S_RUN;
            ready_o <= 1'b1;
          end
        end
        S_RUN: ;
        default: begin
          state     <= S_PLL_RST;
          cnt       <= '0;
          pll_rst_o <= 1'b1;
          rst_n_o   <= '0;
          ready_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
